traffic_light_checker: RTL and testbench

//  Passive protocol checker for the two-way traffic light controller's lamp outputs.

---
 rtl/traffic_light_checker.sv | 156 +++++++++++++++
 tb/tb_traffic_light_checker.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_checker.sv
// Passive checker for the two-way traffic light lamp outputs: decodes the phase, tracks the
// NS_G -> NS_Y -> EW_G -> EW_Y sequence and flags illegal patterns, ordering and dwell errors.
module traffic_light_checker #(
  parameter int unsigned NS_G_TICKS = 5,
  parameter int unsigned NS_Y_TICKS = 2,
  parameter int unsigned EW_G_TICKS = 5,
  parameter int unsigned EW_Y_TICKS = 2,
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned CYC_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             ns_g,
  input  logic             ns_y,
  input  logic             ns_r,
  input  logic             ew_g,
  input  logic             ew_y,
  input  logic             ew_r,
  output logic [1:0]       phase,
  output logic             locked,
  output logic             lamp_err,
  output logic             conflict_err,
  output logic             seq_err,
  output logic             dur_err,
  output logic             err_sticky,
  output logic [CYC_W-1:0] cycle_count
);

  typedef enum logic [1:0] {
    PH_NS_G = 2'd0,
    PH_NS_Y = 2'd1,
    PH_EW_G = 2'd2,
    PH_EW_Y = 2'd3
  } phase_t;

  typedef enum logic {
    ST_SYNC,
    ST_TRACK
  } state_t;

  logic [5:0]       lamp_q;
  logic             tick_q;

  state_t           state_q;
  phase_t           phase_q;
  logic             have_q;
  logic             ovr_q;
  logic [CNT_W-1:0] dwell_q;

  logic             legal;
  phase_t           dec;
  logic             conflict;
  logic             change;
  logic             on_succ;
  logic             tracking;
  logic [CNT_W-1:0] req_cur;
  logic [CNT_W-1:0] dwell_next;
  logic             seq_hit;
  logic             dur_hit;
  logic             overrun_hit;
  logic             wrap_hit;

  function automatic logic [CNT_W-1:0] req_ticks(input phase_t p);
    case (p)
      PH_NS_G: req_ticks = CNT_W'(NS_G_TICKS);
      PH_NS_Y: req_ticks = CNT_W'(NS_Y_TICKS);
      PH_EW_G: req_ticks = CNT_W'(EW_G_TICKS);
      default: req_ticks = CNT_W'(EW_Y_TICKS);
    endcase
  endfunction

  // Pure sampling stage; no reset so the first post-reset decode sees the real lamps.
  always_ff @(posedge clk) begin
    lamp_q <= {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r};
    tick_q <= tick;
  end

  // Unknown or multi-hot values fall through to the illegal default.
  always_comb begin
    legal = 1'b1;
    dec   = PH_NS_G;
    case (lamp_q)
      6'b100_001: dec = PH_NS_G;
      6'b010_001: dec = PH_NS_Y;
      6'b001_100: dec = PH_EW_G;
      6'b001_010: dec = PH_EW_Y;
      default:    legal = 1'b0;
    endcase
    conflict = (lamp_q[5] | lamp_q[4]) & (lamp_q[2] | lamp_q[1]);
  end

  always_comb begin
    tracking    = (state_q == ST_TRACK);
    change      = legal & have_q & (dec != phase_q);
    on_succ     = (dec == phase_t'(phase_q + 2'd1));
    req_cur     = req_ticks(phase_q);
    dwell_next  = (dwell_q == '1) ? dwell_q : dwell_q + 1'b1;
    overrun_hit = tracking & legal & ~change & tick_q & ~ovr_q & (dwell_q == req_cur);
    seq_hit     = tracking & change & ~on_succ;
    dur_hit     = overrun_hit |
                  (tracking & change & on_succ & ~ovr_q & (dwell_q != req_cur));
    wrap_hit    = tracking & change & on_succ & (phase_q == PH_EW_Y);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_SYNC;
      phase_q      <= PH_NS_G;
      have_q       <= 1'b0;
      ovr_q        <= 1'b0;
      dwell_q      <= '0;
      locked       <= 1'b0;
      lamp_err     <= 1'b0;
      conflict_err <= 1'b0;
      seq_err      <= 1'b0;
      dur_err      <= 1'b0;
      err_sticky   <= 1'b0;
      cycle_count  <= '0;
    end else begin
      lamp_err     <= ~legal;
      conflict_err <= conflict;
      seq_err      <= seq_hit;
      dur_err      <= dur_hit;
      err_sticky   <= err_sticky | ~legal | conflict | seq_hit | dur_hit;

      if (!legal) begin
        state_q <= ST_SYNC;
        locked  <= 1'b0;
      end else if (!have_q || change) begin
        // A tick coincident with the change belongs to the new phase.
        have_q  <= 1'b1;
        phase_q <= dec;
        dwell_q <= {{(CNT_W-1){1'b0}}, tick_q};
        ovr_q   <= 1'b0;
        if (change) begin
          if (state_q == ST_SYNC) begin
            state_q <= ST_TRACK;
            locked  <= 1'b1;
          end else if (!on_succ) begin
            state_q <= ST_SYNC;
            locked  <= 1'b0;
          end else if (wrap_hit) begin
            cycle_count <= cycle_count + CYC_W'(1);
          end
        end
      end else begin
        if (tick_q) dwell_q <= dwell_next;
        if (overrun_hit) ovr_q <= 1'b1;
      end
    end
  end

  assign phase = phase_q;

endmodule

// File: tb/tb_traffic_light_checker.sv
// Directed bench for traffic_light_checker: a phase-level reference model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_traffic_light_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic [5:0]  lamp_drv;
  logic        ns_g, ns_y, ns_r, ew_g, ew_y, ew_r;
  logic [1:0]  phase;
  logic        locked, lamp_err, conflict_err, seq_err, dur_err, err_sticky;
  logic [15:0] cycle_count;

  always #5 clk = ~clk;

  assign {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r} = lamp_drv;

  traffic_light_checker #(
    .NS_G_TICKS(5),
    .NS_Y_TICKS(2),
    .EW_G_TICKS(5),
    .EW_Y_TICKS(2),
    .CNT_W(4),
    .CYC_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tick(tick),
    .ns_g(ns_g),
    .ns_y(ns_y),
    .ns_r(ns_r),
    .ew_g(ew_g),
    .ew_y(ew_y),
    .ew_r(ew_r),
    .phase(phase),
    .locked(locked),
    .lamp_err(lamp_err),
    .conflict_err(conflict_err),
    .seq_err(seq_err),
    .dur_err(dur_err),
    .err_sticky(err_sticky),
    .cycle_count(cycle_count)
  );

  int checks = 0;
  int errors = 0;
  int per    = 20;

  int n_lamp = 0, n_conf = 0, n_seq = 0, n_dur = 0;

  function automatic logic [5:0] pat(input int p);
    case (p)
      0:       pat = 6'b100_001;
      1:       pat = 6'b010_001;
      2:       pat = 6'b001_100;
      default: pat = 6'b001_010;
    endcase
  endfunction

  function automatic int req(input int p);
    req = (p == 0 || p == 2) ? 5 : 2;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one step per clock, applied to the lamps seen one edge earlier.
  int m_phase, m_ticks, m_cnt;
  bit m_have, m_locked, m_ovr, m_sticky;
  bit e_lamp, e_conf, e_seq, e_dur;

  task automatic model_step(input logic r, input logic [5:0] x, input logic t);
    int p;
    e_lamp = 0; e_conf = 0; e_seq = 0; e_dur = 0;
    if (r !== 1'b1) begin
      m_phase = 0; m_have = 0; m_locked = 0; m_ticks = 0; m_ovr = 0; m_cnt = 0; m_sticky = 0;
      return;
    end
    p = -1;
    for (int i = 0; i < 4; i++) if (x === pat(i)) p = i;
    e_conf = (x[5] | x[4]) & (x[2] | x[1]);
    if (p < 0) begin
      e_lamp   = 1;
      m_locked = 0;
    end else if (!m_have) begin
      m_have = 1; m_phase = p; m_ticks = int'(t); m_ovr = 0;
    end else if (p != m_phase) begin
      if (m_locked) begin
        if (p == (m_phase + 1) % 4) begin
          if (!m_ovr && m_ticks != req(m_phase)) e_dur = 1;
          if (m_phase == 3) m_cnt = (m_cnt + 1) % 65536;
        end else begin
          e_seq    = 1;
          m_locked = 0;
        end
      end else begin
        m_locked = 1;
      end
      m_phase = p; m_ticks = int'(t); m_ovr = 0;
    end else if (t === 1'b1) begin
      if (m_ticks < 15) m_ticks++;
      if (m_locked && !m_ovr && m_ticks == req(m_phase) + 1) begin
        e_dur = 1;
        m_ovr = 1;
      end
    end
    m_sticky = m_sticky | e_lamp | e_conf | e_seq | e_dur;
  endtask

  logic [5:0] pv_lamp = '0;
  logic       pv_tick = 1'b0;

  always @(posedge clk) begin
    model_step(rst, pv_lamp, pv_tick);
    pv_lamp = lamp_drv;
    pv_tick = tick;
    #1;
    chk("phase", 32'(phase), 32'(m_phase));
    chk("locked", 32'(locked), 32'(m_locked));
    chk("lamp_err", 32'(lamp_err), 32'(e_lamp));
    chk("conflict_err", 32'(conflict_err), 32'(e_conf));
    chk("seq_err", 32'(seq_err), 32'(e_seq));
    chk("dur_err", 32'(dur_err), 32'(e_dur));
    chk("err_sticky", 32'(err_sticky), 32'(m_sticky));
    chk("cycle_count", 32'(cycle_count), 32'(m_cnt));
    if (lamp_err === 1'b1) n_lamp++;
    if (conflict_err === 1'b1) n_conf++;
    if (seq_err === 1'b1) n_seq++;
    if (dur_err === 1'b1) n_dur++;
  end

  task automatic tick_once();
    repeat (per - 1) @(negedge clk) tick = 1'b0;
    @(negedge clk) tick = 1'b1;
  endtask

  // Lamps change on the cycle after the tick that ends the previous phase.
  task automatic drive_phase(input int p, input int n);
    @(negedge clk);
    lamp_drv = pat(p);
    tick     = 1'b0;
    repeat (n) tick_once();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk) tick = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, s0, l0, c0;
    rst      = 1'b0;
    tick     = 1'b0;
    lamp_drv = 6'b111_111;
    @(negedge clk);
    lamp_drv = pat(2);
    tick     = 1'b1;
    @(negedge clk);
    lamp_drv = pat(0);
    tick     = 1'b0;
    @(negedge clk);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_cycle_count", 32'(cycle_count), 32'd0);
    chk("rst_sticky", 32'(err_sticky), 32'd0);
    rst = 1'b1;

    // Clean controller, partial first phase, then three full cycles; last NS_G overruns.
    drive_phase(0, 3);
    d0 = 0;
    for (int i = 0; i < 3; i++) begin
      drive_phase(1, 2);
      drive_phase(2, 5);
      drive_phase(3, 2);
      if (i == 2) begin
        chk("clean_sticky", 32'(err_sticky), 32'd0);
        chk("clean_locked", 32'(locked), 32'd1);
        chk("clean_no_pulses", 32'(n_lamp + n_conf + n_seq + n_dur), 32'd0);
        d0 = n_dur;
        drive_phase(0, 6);
      end else begin
        drive_phase(0, 5);
      end
    end
    drive_phase(1, 2);
    chk("overrun_once", 32'(n_dur - d0), 32'd1);
    chk("count_after_3", 32'(cycle_count), 32'd3);

    // Out-of-order jump NS_G -> EW_G, then re-lock.
    drive_phase(2, 5);
    drive_phase(3, 2);
    drive_phase(0, 5);
    s0 = n_seq;
    drive_phase(2, 3);
    chk("jump_unlocked", 32'(locked), 32'd0);
    chk("jump_seq_once", 32'(n_seq - s0), 32'd1);
    drive_phase(3, 2);
    chk("relock", 32'(locked), 32'd1);
    drive_phase(0, 5);
    chk("count_after_relock", 32'(cycle_count), 32'd5);

    // One-cycle dual green.
    l0 = n_lamp;
    c0 = n_conf;
    @(negedge clk);
    lamp_drv = 6'b100_100;
    tick     = 1'b0;
    @(negedge clk);
    lamp_drv = pat(0);
    idle(4);
    chk("glitch_lamp_once", 32'(n_lamp - l0), 32'd1);
    chk("glitch_conf_once", 32'(n_conf - c0), 32'd1);
    chk("glitch_unlocked", 32'(locked), 32'd0);
    chk("glitch_phase_held", 32'(phase), 32'd0);
    drive_phase(1, 2);
    chk("glitch_relock", 32'(locked), 32'd1);
    drive_phase(2, 5);
    drive_phase(3, 1);
    idle(3);
    chk("pre_reset_count", 32'(cycle_count), 32'd5);
    chk("pre_reset_phase", 32'(phase), 32'd3);

    // Reset mid EW_Y.
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_count", 32'(cycle_count), 32'd0);
    chk("midrst_locked", 32'(locked), 32'd0);
    chk("midrst_phase", 32'(phase), 32'd0);
    chk("midrst_sticky", 32'(err_sticky), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    drive_phase(0, 5);
    drive_phase(1, 2);
    idle(5);
    chk("post_rst_count", 32'(cycle_count), 32'd0);
    chk("post_rst_locked", 32'(locked), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
